// File: rtl/seq_tx.sv
// seq_tx: serial sequence transmitter, MSB-first, with start/busy/done handshake and optional inter-frame gap.
// Optional frame looping is enabled by defining SEQ_TX_REPEAT_EN (adds the repeat_in port).
module seq_tx #(
    parameter int   WIDTH    = 16,
    parameter int   LEN_W    = 5,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len_in,
`ifdef SEQ_TX_REPEAT_EN
    input  logic             repeat_in,
`endif
    output logic             seq_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shadow_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [LEN_W-1:0] len_eff_s;
    logic             loop_s;

    // Zero or oversize length requests mean a full-width frame.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        if ((l == {LEN_W{1'b0}}) || (32'(l) > WIDTH)) begin
            return LEN_W'(WIDTH);
        end else begin
            return l;
        end
    endfunction

    // Shift-based select keeps the index width independent of WIDTH.
    function automatic logic bit_at(input logic [WIDTH-1:0] word, input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted = word >> idx;
        return shifted[0];
    endfunction

    // Effective length of the request and loop decision at end of frame.
    always_comb begin
        len_eff_s = eff_len(len_in);
        loop_s    = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
        loop_s    = repeat_in;
`endif
    end

    // Transmit FSM; outputs are computed for the next cycle and registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            shadow_r  <= {WIDTH{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            idx_r     <= {LEN_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            seq_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shadow_r  <= data_in;
                        len_r     <= len_eff_s;
                        idx_r     <= len_eff_s - LEN_W'(1);
                        state_r   <= ST_SHIFT;
                        seq_out   <= bit_at(data_in, len_eff_s - LEN_W'(1));
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= (len_eff_s == LEN_W'(1));
                    end else begin
                        seq_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (idx_r != {LEN_W{1'b0}}) begin
                        idx_r     <= idx_r - LEN_W'(1);
                        seq_out   <= bit_at(shadow_r, idx_r - LEN_W'(1));
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= (idx_r == LEN_W'(1));
                    end else if (GAP > 0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_W'(GAP - 1);
                        seq_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else if (loop_s) begin
                        // Replay from the shadow word without a gap bit.
                        idx_r     <= len_r - LEN_W'(1);
                        seq_out   <= bit_at(shadow_r, len_r - LEN_W'(1));
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= (len_r == LEN_W'(1));
                    end else begin
                        state_r   <= ST_IDLE;
                        seq_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != {GAP_W{1'b0}}) begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                        seq_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else if (loop_s) begin
                        state_r   <= ST_SHIFT;
                        idx_r     <= len_r - LEN_W'(1);
                        seq_out   <= bit_at(shadow_r, len_r - LEN_W'(1));
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= (len_r == LEN_W'(1));
                    end else begin
                        state_r   <= ST_IDLE;
                        seq_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    seq_out   <= IDLE_BIT;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial sequence transmitter: captures a parallel word plus bit count on a start strobe and shifts it out MSB-first, one bit per clock, on a single serial line. It is the stimulus/transmit end of the serial pattern path and drives the `seq_in` of the bit-pattern detector FSMs, for example the "0011" Moore detector. It provides a start/busy/done handshake and an optional inter-frame gap at the idle line level.

## Interface
- `WIDTH`, 16: maximum frame length in bits.
- `LEN_W`, 5: width of `len_in`; must be at least clog2(WIDTH+1).
- `GAP`, 0: idle cycles inserted after every frame; 0 means no gap.
- `IDLE_BIT`, 1'b1: line level driven while not sending data.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets immediately.
- `start`  in  1  frame request; sampled only in IDLE.
- `data_in`  in  WIDTH  frame payload; bits [len-1:0] are sent.
- `len_in`  in  LEN_W  frame length in bits.
- `repeat_in`  in  1  loop request; present only with `SEQ_TX_REPEAT_EN`.
- `seq_out`  out  1  serial data, registered.
- `bit_valid`  out  1  high while `seq_out` carries a payload bit.
- `busy`  out  1  high in SHIFT and GAP.
- `done`  out  1  one-cycle pulse coincident with the last payload bit.

## Operation
- States:
  - IDLE: line idle, waits for `start`.
  - SHIFT: sends payload bits.
  - GAP: holds the idle level for `GAP` cycles.
- Reset (`reset`=0): state IDLE, `seq_out`=IDLE_BIT, `bit_valid`=0, `busy`=0, `done`=0, counters 0. Shadow registers are don't-care.
- Length rule:
  - Effective length L = WIDTH when `len_in`=0 or `len_in`>WIDTH.
  - Otherwise L = `len_in`.
- Start accept: IDLE and `start`=1 at an edge.
  - Latch `data_in` into the shadow word and L into the shadow length.
  - Load the bit index with L-1 and go to SHIFT.
- SHIFT:
  - `seq_out`=shadow[index], `bit_valid`=1, `busy`=1.
  - Index decrements by 1 at each edge.
  - `done`=1 in the cycle index==0.
- End of frame (edge in SHIFT with index==0):
  - GAP>0: go to GAP and load the gap counter with GAP-1.
  - GAP=0: apply the loop rule below.
- GAP: `seq_out`=IDLE_BIT, `bit_valid`=0, `busy`=1.
  - Counter decrements each edge.
  - At counter==0, apply the loop rule.
- Loop rule:
  - With repeat enabled and `repeat_in`=1: reload index=L-1 from the shadow length and go to SHIFT; the shadow word is not re-sampled.
  - Otherwise: go to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `data_in` and `len_in` are ignored except at the accepting edge.
- Reset asserted mid-frame aborts immediately. The line returns to IDLE_BIT with no `done` pulse.

## Timing
- Latency: the first payload bit appears on `seq_out` in the cycle after the accepting edge.
- Frame occupancy: `busy` is high for exactly L+GAP cycles per frame.
- `done` pulses once per frame, in cycle L of that frame.
- Back-to-back frames:
  - With GAP=0 and repeat active, the bit stream is continuous with no idle bit.
  - Without repeat, IDLE lasts at least 1 cycle (`busy`=0) before the next start can be accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `SEQ_TX_REPEAT_EN`.
- Defined:
  - The `repeat_in` port exists.
  - A frame restarts from the shadow registers while `repeat_in`=1 at the end of frame (GAP=0) or at the final GAP cycle (GAP>0).
- Undefined:
  - No `repeat_in` port.
  - The FSM always returns to IDLE after each frame; the loop path is not synthesized.

## Test plan
- Reset values: hold `reset`=0 -> `seq_out`=1, `busy`=0, `bit_valid`=0, `done`=0. Deassert `reset` mid-frame, then reassert it -> outputs return to reset values asynchronously, with no `done` pulse.
- Single frame: `data_in`=16'h0003, `len_in`=4, 1-cycle `start` -> `seq_out`=0,0,1,1 on the next 4 cycles and `done` high in cycle 4. Fed into the 0011 detector, its output is 1 for one cycle, one cycle later.
- Length boundaries:
  - `len_in`=0 with `data_in`=16'hA5C3 -> 16 bits 1010010111000011.
  - `len_in`=1, `data_in`=1 -> a single bit 1 with `busy` and `done` high for 1 cycle.
- Gap: GAP=2, `len_in`=3, `data_in`=3'b101 -> 1,0,1, then 2 cycles of `seq_out`=1 with `bit_valid`=0, `busy`=1, then `busy`=0.
- Start while busy: `start` pulse in frame cycle 2 -> ignored, only one `done`, `data_in` change not reflected.
- Repeat (`SEQ_TX_REPEAT_EN`, GAP=0): `len_in`=4, `data_in`=4'b0011, `repeat_in`=1 for 3 frames -> continuous 001100110011, `done` every 4th cycle, `busy`=0 one cycle after `repeat_in` drops.
